// File: rtl/ex_stall_ctrl_if.sv
// Signal bundle between the EX-stage pipeline and its interlock controller.
// The master modport is the pipeline side and the slave modport is the controller.
interface ex_stall_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        ex_muldiv;
  logic        ex_is_div;
  logic        ex_div_zero;
  logic        md_start;
  logic        hilo_we;
  logic        div0_flag;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_write;
  logic        idex_flush;
  logic        exmem_flush;
  logic        busy;
  logic [31:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt,
           ex_muldiv, ex_is_div, ex_div_zero,
    input  md_start, hilo_we, div0_flag, pc_write, ifid_write, idex_write,
           idex_flush, exmem_flush, busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt,
           ex_muldiv, ex_is_div, ex_div_zero,
    output md_start, hilo_we, div0_flag, pc_write, ifid_write, idex_write,
           idex_flush, exmem_flush, busy, stall_count
  );
endinterface

// File: rtl/ex_stall_ctrl.sv
// EX-stage interlock: one-bubble load-use stall plus sequencing of the iterative mul/div unit.
//   state   | meaning
//   S_IDLE  | no mul/div in flight; load-use detect active; a mul/div in EX starts here
//   S_BUSY  | mul/div unit iterating; IF/ID/EX frozen, EX/MEM bubbled
//   S_DRAIN | result ready; HI/LO written (unless div by zero), instruction leaves EX
module ex_stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        CLK,
  input  logic        RST,
  ex_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Latencies of 1 or 2 have no BUSY phase; the load value is then never used.
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
  localparam bit               MUL_SHORT = (MUL_CYCLES <= 2);
  localparam bit               DIV_SHORT = (DIV_CYCLES <= 2);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_dec;
  logic              r_div0;
  logic              w_div0_set;
  logic [31:0]       r_stall_cnt;
  logic              w_lu;
  logic              w_div_zero;
  logic              w_short;

  assign w_lu = bus.idex_memread && (bus.idex_rt != 5'd0) &&
                ((bus.idex_rt == bus.id_rs) ||
                 (bus.id_uses_rt && (bus.idex_rt == bus.id_rt)));

  assign w_div_zero = bus.ex_is_div && bus.ex_div_zero;
  assign w_short    = bus.ex_is_div ? DIV_SHORT : MUL_SHORT;
  assign w_cnt_dec  = r_cnt - CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div0      <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (bus.md_start)
        r_div0 <= 1'b0;
      else if (w_div0_set)
        r_div0 <= 1'b1;
      if (!bus.pc_write)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_div0_set      = 1'b0;
    bus.md_start    = 1'b0;
    bus.hilo_we     = 1'b0;
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_write  = 1'b1;
    bus.idex_flush  = 1'b0;
    bus.exmem_flush = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.ex_muldiv) begin
          // Holding ID also covers any coincident load-use hazard, so no bubble here.
          bus.pc_write    = 1'b0;
          bus.ifid_write  = 1'b0;
          bus.idex_write  = 1'b0;
          bus.exmem_flush = 1'b1;
          if (w_div_zero) begin
            w_div0_set  = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            bus.md_start = 1'b1;
            w_cnt_nxt    = bus.ex_is_div ? DIV_LOAD : MUL_LOAD;
            w_state_nxt  = w_short ? S_DRAIN : S_BUSY;
          end
        end else if (w_lu) begin
          bus.pc_write   = 1'b0;
          bus.ifid_write = 1'b0;
          bus.idex_flush = 1'b1;
        end
      end

      S_BUSY: begin
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.idex_write  = 1'b0;
        bus.exmem_flush = 1'b1;
        w_cnt_nxt       = w_cnt_dec;
        if (w_cnt_dec == '0)
          w_state_nxt = S_DRAIN;
      end

      S_DRAIN: begin
        // The flag is only still set in DRAIN when this sequence was the div-by-zero one.
        bus.hilo_we = !r_div0;
        if (w_lu) begin
          bus.pc_write   = 1'b0;
          bus.ifid_write = 1'b0;
          bus.idex_flush = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.div0_flag   = r_div0;
  assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_ex_stall_ctrl.sv
// Directed and randomized stimulus for ex_stall_ctrl, checked cycle by cycle against
// a model that tracks each mul/div sequence as a position within its total EX occupancy.
module tb_ex_stall_ctrl;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  ex_stall_ctrl_if bus ();

  ex_stall_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model: m_pos = 0 when idle, else the 1-based EX cycle of the running sequence
  int          m_pos   = 0;
  int          m_len   = 0;
  bit          m_z     = 1'b0;
  bit          m_div0  = 1'b0;
  logic [31:0] m_stall = 32'd0;
  int          n_hilo  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urt, input bit mr, input logic [4:0] exrt,
                      input bit md, input bit isdiv, input bit dz);
    bit lu, start_seq, freeze;
    bit e_start, e_hilo, e_pc, e_ifid, e_idw, e_idf, e_exf;
    RST              = rst;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rt   = urt;
    bus.idex_memread = mr;
    bus.idex_rt      = exrt;
    bus.ex_muldiv    = md;
    bus.ex_is_div    = isdiv;
    bus.ex_div_zero  = dz;
    @(negedge CLK);

    lu = mr && (exrt != 0) && ((exrt == rs) || (urt && (exrt == rt)));
    start_seq = 1'b0;
    freeze    = 1'b0;
    e_start = 0; e_hilo = 0; e_pc = 1; e_ifid = 1; e_idw = 1; e_idf = 0; e_exf = 0;
    if (m_pos != 0 && m_pos < m_len) begin
      freeze = 1'b1;
    end else if (m_pos == 0 && md) begin
      freeze    = 1'b1;
      start_seq = 1'b1;
      e_start   = !(isdiv && dz);
    end else begin
      if (m_pos != 0) e_hilo = !m_z;
      if (lu) begin
        e_pc = 0; e_ifid = 0; e_idf = 1;
      end
    end
    if (freeze) begin
      e_pc = 0; e_ifid = 0; e_idw = 0; e_exf = 1;
    end

    if (!rst) begin
      chk("md_start",    32'(bus.md_start),    32'(e_start));
      chk("hilo_we",     32'(bus.hilo_we),     32'(e_hilo));
      chk("pc_write",    32'(bus.pc_write),    32'(e_pc));
      chk("ifid_write",  32'(bus.ifid_write),  32'(e_ifid));
      chk("idex_write",  32'(bus.idex_write),  32'(e_idw));
      chk("idex_flush",  32'(bus.idex_flush),  32'(e_idf));
      chk("exmem_flush", 32'(bus.exmem_flush), 32'(e_exf));
      chk("busy",        32'(bus.busy),        32'(m_pos != 0));
      chk("div0_flag",   32'(bus.div0_flag),   32'(m_div0));
      chk("stall_count", bus.stall_count,      m_stall);
      if (bus.hilo_we) n_hilo++;
    end

    if (rst) begin
      m_pos   = 0;
      m_div0  = 1'b0;
      m_stall = 32'd0;
    end else begin
      if (!e_pc) m_stall = m_stall + 32'd1;
      if (start_seq) begin
        m_z   = isdiv && dz;
        m_len = m_z ? 2 : ((isdiv ? DIV_N : MUL_N) < 2 ? 2 : (isdiv ? DIV_N : MUL_N));
        m_pos = 2;
        if (e_start) m_div0 = 1'b0;
        if (m_z)     m_div0 = 1'b1;
      end else if (m_pos != 0) begin
        m_pos = (m_pos == m_len) ? 0 : m_pos + 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // load-use: lw $t0 in EX, consumer reads $t0 as rs
    step(0, 8, 3, 1, 1, 8, 0, 0, 0);
    idle(1);
    chk("lu_stall_count", bus.stall_count, 32'd1);
    // same with idex_rt = 0: no hazard
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 4, 9, 1, 1, 9, 0, 0, 0);
    step(0, 4, 9, 0, 1, 9, 0, 0, 0);
    idle(1);

    // reset counter for an isolated mult measurement
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_hilo = 0;
    for (int i = 0; i < MUL_N; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    chk("mult_stall_count", bus.stall_count, 32'd3);
    chk("mult_hilo_once", 32'(n_hilo), 32'd1);

    // div followed back-to-back by another div
    n_hilo = 0;
    for (int i = 0; i < DIV_N + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < DIV_N - 1; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    chk("div_b2b_hilo", 32'(n_hilo), 32'd2);

    // divide by zero, then a mult clears the flag
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("div0_set", 32'(bus.div0_flag), 32'd1);
    for (int i = 0; i < MUL_N; i++) step(0, 0, 0, 0, 0, 0, (i == 0), 0, 0);
    idle(1);

    // mul/div and load-use together
    step(0, 5, 0, 0, 1, 5, 1, 0, 0);
    idle(MUL_N);

    // reset during BUSY cycle 10 of a div
    n_hilo = 0;
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 2; i < 10; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(DIV_N + 2);
    chk("rst_no_hilo", 32'(n_hilo), 32'd0);
    chk("rst_stall_zero", bus.stall_count, 32'd0);

    // randomized traffic on a small register set so hazards collide often
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 399) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
